mpu_xfer_seq: RTL and testbench



---
 rtl/mpu_xfer_seq.sv | 242 ++++++++++++++++++++++++
 tb/tb_mpu_xfer_seq.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpu_xfer_seq.sv
// mpu_xfer_seq - data-transfer sequencer for the MPU host interface.
//
// Takes a four-word header (ID, stride, base, length) from the host word
// stream, then moves exactly `length` words between host and TPU data
// memory at addresses base + k*stride (mod 2^ADDR_WIDTH). Stores pass
// host words straight through to memory; loads stage read returns in a
// 4-entry buffer. A one-cycle O_End pulse closes every transfer.
//
// Handshakes: a transfer on any valid/ready pair happens in a cycle where
// both are high at the rising clock edge; valid never waits on ready.
//
// Ports
//   clock, reset                  clock, synchronous active-high reset
//   I_Start_St / I_Start_Ld       start store / load (sampled in IDLE only)
//   I_Valid, I_Data, O_Ready      host word stream (header and store data)
//   O_Valid, O_Data, I_Ready      load data to host
//   O_Mem_Req/We/Addr/WData       memory request, accepted with I_Mem_Rdy
//   I_Mem_RValid, I_Mem_RData     in-order read return, no backpressure
//   O_Id                          ID of the current / last transfer
//   O_Busy                        high outside IDLE
//   O_End                         one-cycle end-of-transfer pulse
//   O_Dbg_State                   current FSM state (debug observation)
module mpu_xfer_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int ID_WIDTH   = 8,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  I_Start_St,
    input  logic                  I_Start_Ld,
    input  logic                  I_Valid,
    input  logic [DATA_WIDTH-1:0] I_Data,
    output logic                  O_Ready,
    output logic                  O_Valid,
    output logic [DATA_WIDTH-1:0] O_Data,
    input  logic                  I_Ready,
    output logic                  O_Mem_Req,
    output logic                  O_Mem_We,
    output logic [ADDR_WIDTH-1:0] O_Mem_Addr,
    output logic [DATA_WIDTH-1:0] O_Mem_WData,
    input  logic                  I_Mem_Rdy,
    input  logic                  I_Mem_RValid,
    input  logic [DATA_WIDTH-1:0] I_Mem_RData,
    output logic [ID_WIDTH-1:0]   O_Id,
    output logic                  O_Busy,
    output logic                  O_End,
    output logic [2:0]            O_Dbg_State
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_HDR_ID     = 3'd1,
        S_HDR_STRIDE = 3'd2,
        S_HDR_BASE   = 3'd3,
        S_HDR_LEN    = 3'd4,
        S_ST_DATA    = 3'd5,
        S_LD_DATA    = 3'd6,
        S_DONE       = 3'd7
    } state_t;

    state_t                state_q, state_d;
    logic                  is_store_q, is_store_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [ADDR_WIDTH-1:0] stride_q, stride_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  done_cnt_q, done_cnt_d;   // words completed (store handshakes / load pops)
    logic [LEN_WIDTH-1:0]  issued_q, issued_d;       // load read requests accepted
    logic [2:0]            outst_q, outst_d;         // reads issued but not yet returned
    logic [2:0]            fcnt_q, fcnt_d;           // words held in the return buffer
    logic [1:0]            wptr_q, wptr_d;
    logic [1:0]            rptr_q, rptr_d;
    logic [DATA_WIDTH-1:0] fifo_q [4];
    logic [DATA_WIDTH-1:0] fifo_d [4];

    logic                  mem_acc;
    logic                  push;
    logic                  pop;
    logic                  last_word;
    logic [3:0]            credit_used;
    logic [LEN_WIDTH-1:0]  hdr_len;

    assign last_word   = (done_cnt_q == len_q - LEN_WIDTH'(1));
    assign credit_used = {1'b0, outst_q} + {1'b0, fcnt_q};
    assign hdr_len     = I_Data[LEN_WIDTH-1:0];
    assign O_Id        = id_q;
    assign O_Busy      = (state_q != S_IDLE);
    assign O_Dbg_State = state_q;

    always_comb begin
        state_d     = state_q;
        is_store_d  = is_store_q;
        id_d        = id_q;
        stride_d    = stride_q;
        addr_d      = addr_q;
        len_d       = len_q;
        done_cnt_d  = done_cnt_q;
        issued_d    = issued_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        fifo_d      = fifo_q;
        mem_acc     = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        O_Ready     = 1'b0;
        O_Valid     = 1'b0;
        O_Data      = '0;
        O_Mem_Req   = 1'b0;
        O_Mem_We    = 1'b0;
        O_Mem_WData = '0;
        O_End       = 1'b0;

        case (state_q)
            S_IDLE: begin
                done_cnt_d = '0;
                issued_d   = '0;
                // Store has priority when both starts arrive together.
                if (I_Start_St) begin
                    is_store_d = 1'b1;
                    state_d    = S_HDR_ID;
                end else if (I_Start_Ld) begin
                    is_store_d = 1'b0;
                    state_d    = S_HDR_ID;
                end
            end
            S_HDR_ID: begin
                O_Ready = 1'b1;
                if (I_Valid) begin
                    id_d    = I_Data[ID_WIDTH-1:0];
                    state_d = S_HDR_STRIDE;
                end
            end
            S_HDR_STRIDE: begin
                O_Ready = 1'b1;
                if (I_Valid) begin
                    stride_d = I_Data[ADDR_WIDTH-1:0];
                    state_d  = S_HDR_BASE;
                end
            end
            S_HDR_BASE: begin
                O_Ready = 1'b1;
                // The base goes straight into the address register; nothing
                // drives the memory port before the data phase starts.
                if (I_Valid) begin
                    addr_d  = I_Data[ADDR_WIDTH-1:0];
                    state_d = S_HDR_LEN;
                end
            end
            S_HDR_LEN: begin
                O_Ready = 1'b1;
                if (I_Valid) begin
                    len_d = hdr_len;
                    if (hdr_len == '0)  state_d = S_DONE;
                    else if (is_store_q) state_d = S_ST_DATA;
                    else                 state_d = S_LD_DATA;
                end
            end
            S_ST_DATA: begin
                O_Mem_Req   = I_Valid;
                O_Mem_We    = 1'b1;
                O_Mem_WData = I_Data;
                O_Ready     = I_Mem_Rdy;
                if (I_Valid && I_Mem_Rdy) begin
                    addr_d     = addr_q + stride_q;
                    done_cnt_d = done_cnt_q + LEN_WIDTH'(1);
                    if (last_word) state_d = S_DONE;
                end
            end
            S_LD_DATA: begin
                // Credit rule: reads in flight plus buffered words never
                // exceed the buffer depth, so a return always has a slot.
                O_Mem_Req = (issued_q < len_q) && (credit_used < 4'd4);
                mem_acc   = O_Mem_Req && I_Mem_Rdy;
                push      = I_Mem_RValid;
                O_Valid   = (fcnt_q != 3'd0);
                O_Data    = fifo_q[rptr_q];
                pop       = O_Valid && I_Ready;
                if (mem_acc) begin
                    issued_d = issued_q + LEN_WIDTH'(1);
                    addr_d   = addr_q + stride_q;
                end
                if (push) begin
                    fifo_d[wptr_q] = I_Mem_RData;
                    wptr_d         = wptr_q + 2'd1;
                end
                if (pop) begin
                    rptr_d     = rptr_q + 2'd1;
                    done_cnt_d = done_cnt_q + LEN_WIDTH'(1);
                    if (last_word) state_d = S_DONE;
                end
            end
            S_DONE: begin
                O_End   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        outst_d = outst_q + {2'b00, mem_acc} - {2'b00, push};
        fcnt_d  = fcnt_q + {2'b00, push} - {2'b00, pop};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            is_store_q <= 1'b0;
            id_q       <= '0;
            stride_q   <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            done_cnt_q <= '0;
            issued_q   <= '0;
            outst_q    <= '0;
            fcnt_q     <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            id_q       <= id_d;
            stride_q   <= stride_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            done_cnt_q <= done_cnt_d;
            issued_q   <= issued_d;
            outst_q    <= outst_d;
            fcnt_q     <= fcnt_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
        end
    end

    // Buffer storage needs no reset: only entries counted by fcnt_q are read.
    always_ff @(posedge clock) begin
        fifo_q <= fifo_d;
    end

    assign O_Mem_Addr = addr_q;

endmodule

// File: tb/tb_mpu_xfer_seq.sv
// tb_mpu_xfer_seq - directed bench for mpu_xfer_seq.
// Inputs change 1 time unit after the rising edge; outputs are checked
// away from the edge. A monitor checks memory writes and host pops against
// expected queues; a responder returns reads with a 2-cycle latency.
module tb_mpu_xfer_seq;

    logic        clock = 1'b0;
    logic        reset;
    logic        I_Start_St, I_Start_Ld, I_Valid, I_Ready;
    logic [31:0] I_Data;
    logic        O_Ready, O_Valid;
    logic [31:0] O_Data;
    logic        O_Mem_Req, O_Mem_We;
    logic [15:0] O_Mem_Addr;
    logic [31:0] O_Mem_WData;
    logic        I_Mem_Rdy;
    logic        I_Mem_RValid = 1'b0;
    logic [31:0] I_Mem_RData  = '0;
    logic [7:0]  O_Id;
    logic        O_Busy, O_End;
    logic [2:0]  O_Dbg_State;

    int n_asserts = 0;
    int n_fails   = 0;
    int cyc       = 0;
    int last_hs_cyc = -1;
    int hdr_len_cyc = -1;
    int req_cnt     = 0;
    int pops        = 0;
    int rv_cnt      = 0;
    int ld_inflight = 0;

    logic [47:0] exp_wr_q[$];     // {addr, data}
    logic [31:0] exp_rd_q[$];
    logic [15:0] pend_addr_q[$];
    int          pend_due_q[$];

    mpu_xfer_seq dut (
        .clock(clock), .reset(reset),
        .I_Start_St(I_Start_St), .I_Start_Ld(I_Start_Ld),
        .I_Valid(I_Valid), .I_Data(I_Data), .O_Ready(O_Ready),
        .O_Valid(O_Valid), .O_Data(O_Data), .I_Ready(I_Ready),
        .O_Mem_Req(O_Mem_Req), .O_Mem_We(O_Mem_We), .O_Mem_Addr(O_Mem_Addr),
        .O_Mem_WData(O_Mem_WData), .I_Mem_Rdy(I_Mem_Rdy),
        .I_Mem_RValid(I_Mem_RValid), .I_Mem_RData(I_Mem_RData),
        .O_Id(O_Id), .O_Busy(O_Busy), .O_End(O_End), .O_Dbg_State(O_Dbg_State)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string pfx);
        check({pfx, "_ready"},   O_Ready, 0);
        check({pfx, "_valid"},   O_Valid, 0);
        check({pfx, "_data"},    O_Data, 0);
        check({pfx, "_memreq"},  O_Mem_Req, 0);
        check({pfx, "_memwe"},   O_Mem_We, 0);
        check({pfx, "_addr"},    O_Mem_Addr, 0);
        check({pfx, "_wdata"},   O_Mem_WData, 0);
        check({pfx, "_id"},      O_Id, 0);
        check({pfx, "_busy"},    O_Busy, 0);
        check({pfx, "_end"},     O_End, 0);
        check({pfx, "_state"},   O_Dbg_State, 0);
    endtask

    // Monitor: memory writes, read issue, host pops.
    always @(negedge clock) begin
        if (reset) begin
            ld_inflight = 0;
        end else begin
            if (O_Mem_Req && I_Mem_Rdy) begin
                req_cnt++;
                if (O_Mem_We) begin
                    check("wr_expected", exp_wr_q.size() > 0, 1);
                    if (exp_wr_q.size() > 0) begin
                        logic [47:0] e;
                        e = exp_wr_q.pop_front();
                        check("wr_addr", O_Mem_Addr, e[47:32]);
                        check("wr_data", O_Mem_WData, e[31:0]);
                    end
                    last_hs_cyc = cyc;
                end else begin
                    pend_addr_q.push_back(O_Mem_Addr);
                    pend_due_q.push_back(cyc + 2);
                    ld_inflight++;
                    check("ld_credit", ld_inflight <= 4, 1);
                end
            end
            if (O_Valid && I_Ready) begin
                check("rd_expected", exp_rd_q.size() > 0, 1);
                if (exp_rd_q.size() > 0) check("rd_data", O_Data, exp_rd_q.pop_front());
                ld_inflight--;
                pops++;
                last_hs_cyc = cyc;
            end
        end
    end

    // Memory responder: each accepted read returns two cycles later.
    always @(posedge clock) begin
        #1;
        I_Mem_RValid = 1'b0;
        I_Mem_RData  = '0;
        if (pend_due_q.size() > 0 && pend_due_q[0] == cyc) begin
            logic [15:0] a;
            a = pend_addr_q.pop_front();
            void'(pend_due_q.pop_front());
            I_Mem_RValid = 1'b1;
            I_Mem_RData  = 32'hD000_0000 | {16'h0, a};
            rv_cnt++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_xfer(input logic st, input logic ld, input logic [31:0] id,
                              input logic [31:0] stride, input logic [31:0] base,
                              input logic [31:0] len);
        I_Start_St = st;
        I_Start_Ld = ld;
        tick();
        I_Start_St = 1'b0;
        I_Start_Ld = 1'b0;
        I_Valid = 1'b1;
        I_Data  = id;
        #1;
        check("hdr_ready", O_Ready, 1);
        check("hdr_busy", O_Busy, 1);
        tick();
        I_Data = stride;
        tick();
        I_Data = base;
        tick();
        I_Data = len;
        hdr_len_cyc = cyc;
        tick();
        I_Valid = 1'b0;
        I_Data  = '0;
    endtask

    task automatic wait_end(input int bound, output int end_cyc);
        end_cyc = -1;
        for (int i = 0; i < bound; i++) begin
            #1;
            if (O_End) begin
                end_cyc = cyc;
                break;
            end
            tick();
        end
        check("end_seen", end_cyc >= 0, 1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int end_cyc;
        int req0;
        int pops0;
        int rv0;
        reset = 1'b1;
        I_Start_St = 1'b0;
        I_Start_Ld = 1'b0;
        I_Valid = 1'b0;
        I_Data  = '0;
        I_Ready = 1'b0;
        I_Mem_Rdy = 1'b1;
        repeat (3) tick();
        #1;
        chk_all_zero("rst");
        reset = 1'b0;
        tick();

        // Store: ID 5, stride 2, base 0x10, three words.
        exp_wr_q.push_back({16'h0010, 32'hAAAA_0001});
        exp_wr_q.push_back({16'h0012, 32'hAAAA_0002});
        exp_wr_q.push_back({16'h0014, 32'hAAAA_0003});
        start_xfer(1, 0, 32'h5, 32'h2, 32'h10, 32'h3);
        check("st_id", O_Id, 8'h05);
        for (int k = 1; k <= 3; k++) begin
            I_Valid = 1'b1;
            I_Data  = 32'hAAAA_0000 + k;
            tick();
        end
        I_Valid = 1'b0;
        wait_end(10, end_cyc);
        check("st_end_timing", end_cyc, last_hs_cyc + 1);
        check("st_all_written", exp_wr_q.size(), 0);
        tick();
        #1;
        check("st_end_pulse", O_End, 0);
        check("st_idle", O_Busy, 0);

        // Load: ID 1, stride 1, base 0x20, six words, host stalled 5 cycles.
        for (int k = 0; k < 6; k++) exp_rd_q.push_back(32'hD000_0020 + k);
        start_xfer(0, 1, 32'h1, 32'h1, 32'h20, 32'h6);
        check("ld_no_hdr_ready", O_Ready, 0);
        repeat (5) tick();
        #1;
        check("ld_inflight_full", ld_inflight, 4);
        check("ld_full_no_req", O_Mem_Req, 0);
        check("ld_full_valid", O_Valid, 1);
        check("ld_head_data", O_Data, 32'hD000_0020);
        I_Ready = 1'b1;
        wait_end(40, end_cyc);
        check("ld_end_timing", end_cyc, last_hs_cyc + 1);
        check("ld_all_read", exp_rd_q.size(), 0);
        check("ld_id", O_Id, 8'h01);
        tick();

        // Zero length, store then load.
        req0 = req_cnt;
        start_xfer(1, 0, 32'h42, 32'h1, 32'h300, 32'h0);
        wait_end(5, end_cyc);
        check("z_st_end_timing", end_cyc, hdr_len_cyc + 1);
        tick();
        start_xfer(0, 1, 32'h43, 32'h1, 32'h300, 32'h0);
        wait_end(5, end_cyc);
        check("z_ld_end_timing", end_cyc, hdr_len_cyc + 1);
        check("z_no_mem_req", req_cnt, req0);
        tick();

        // Address wrap at the top of the address space.
        exp_wr_q.push_back({16'hFFFE, 32'h0000_00B0});
        exp_wr_q.push_back({16'hFFFF, 32'h0000_00B1});
        exp_wr_q.push_back({16'h0000, 32'h0000_00B2});
        exp_wr_q.push_back({16'h0001, 32'h0000_00B3});
        start_xfer(1, 0, 32'h6, 32'h1, 32'hFFFE, 32'h4);
        for (int k = 0; k < 4; k++) begin
            I_Valid = 1'b1;
            I_Data  = 32'hB0 + k;
            tick();
        end
        I_Valid = 1'b0;
        wait_end(10, end_cyc);
        check("wrap_all_written", exp_wr_q.size(), 0);
        tick();

        // Both starts together: store wins.
        exp_wr_q.push_back({16'h0200, 32'h0000_0077});
        start_xfer(1, 1, 32'h7, 32'h1, 32'h200, 32'h1);
        check("both_is_store", O_Mem_We, 1);
        I_Valid = 1'b1;
        I_Data  = 32'h77;
        tick();
        I_Valid = 1'b0;
        wait_end(10, end_cyc);
        check("both_written", exp_wr_q.size(), 0);
        tick();

        // Start pulse during LD_DATA is ignored.
        for (int k = 0; k < 3; k++) exp_rd_q.push_back(32'hD000_0040 + 4 * k);
        start_xfer(0, 1, 32'h33, 32'h4, 32'h40, 32'h3);
        I_Start_St = 1'b1;
        tick();
        I_Start_St = 1'b0;
        wait_end(30, end_cyc);
        check("ign_all_read", exp_rd_q.size(), 0);
        check("ign_id", O_Id, 8'h33);
        tick();
        #1;
        check("ign_idle_after", O_Busy, 0);
        tick();

        // Reset in the middle of a load with reads outstanding.
        for (int k = 0; k < 5; k++) exp_rd_q.push_back(32'hD000_0080 + k);
        pops0 = pops;
        start_xfer(0, 1, 32'h9, 32'h1, 32'h80, 32'h5);
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            #1;
            if (pops == pops0 + 2) break;
        end
        check("mid_two_popped", pops, pops0 + 2);
        check("mid_reads_pending", pend_due_q.size() > 0, 1);
        rv0 = rv_cnt;
        reset = 1'b1;
        tick();
        #1;
        chk_all_zero("mid_rst");
        reset = 1'b0;
        exp_rd_q.delete();
        for (int i = 0; i < 4; i++) begin
            tick();
            #1;
            check("late_rv_no_valid", O_Valid, 0);
            check("late_rv_idle", O_Busy, 0);
        end
        check("late_rv_seen", rv_cnt > rv0, 1);

        // A store after the reset completes normally.
        exp_wr_q.push_back({16'h0100, 32'h0000_0011});
        exp_wr_q.push_back({16'h0103, 32'h0000_0022});
        start_xfer(1, 0, 32'hA, 32'h3, 32'h100, 32'h2);
        I_Valid = 1'b1;
        I_Data  = 32'h11;
        tick();
        I_Data  = 32'h22;
        tick();
        I_Valid = 1'b0;
        wait_end(10, end_cyc);
        check("post_rst_end_timing", end_cyc, last_hs_cyc + 1);
        check("post_rst_written", exp_wr_q.size(), 0);
        check("post_rst_id", O_Id, 8'h0A);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
